// File: rtl/clock_set_ctrl.sv
// Settable 24-hour clock with two debounced pushbuttons.
// The mode button cycles RUN -> SET_HR -> SET_MIN; the inc button edits the selected field.
module clock_set_ctrl #(
  parameter int unsigned CLK_HZ          = 100000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       pb_mode,
  input  logic       pb_inc,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] mode_state,
  output logic       blink,
  output logic       led
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);
  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } mode_t;

  // Bit 0 is the mode button, bit 1 the inc button.
  logic [1:0]    sync_a;
  logic [1:0]    sync_b;
  logic [1:0]    level;
  logic [1:0]    level_q;
  logic [1:0]    press;
  logic [CW-1:0] db_cnt [2];

  mode_t         state;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nxt;
  logic          tick;
  logic          mode_evt;
  logic          inc_evt;
  logic          leave_set;
  logic          in_set_nxt;

  // A level flips only after the synchronized input disagrees with it for a full run.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_a  <= '0;
      sync_b  <= '0;
      level   <= '0;
      level_q <= '0;
      press   <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync_a  <= {pb_inc, pb_mode};
      sync_b  <= sync_a;
      level_q <= level;
      press   <= level & ~level_q;
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] != level[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            level[i]  <= sync_b[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign mode_evt   = press[0];
  assign inc_evt    = press[1];
  assign tick       = (presc == PRESC_LAST);
  assign leave_set  = mode_evt && (state == SET_MIN);
  assign presc_nxt  = (tick || leave_set) ? '0 : presc + 1'b1;
  assign in_set_nxt = mode_evt ? (state != SET_MIN) : (state != RUN);
  assign mode_state = state;

  // blink and led are computed from post-edge state so they line up with the registers they describe.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state   <= RUN;
      presc   <= '0;
      hours   <= '0;
      minutes <= '0;
      seconds <= '0;
      blink   <= 1'b0;
      led     <= 1'b0;
    end else begin
      presc <= presc_nxt;
      led   <= in_set_nxt;
      blink <= in_set_nxt && (presc_nxt < PRESC_HALF);
      case (state)
        RUN: begin
          if (mode_evt) begin
            state <= SET_HR;
          end
          if (tick) begin
            if (seconds == 6'd59) begin
              seconds <= '0;
              if (minutes == 6'd59) begin
                minutes <= '0;
                hours   <= (hours == 5'd23) ? '0 : hours + 5'd1;
              end else begin
                minutes <= minutes + 6'd1;
              end
            end else begin
              seconds <= seconds + 6'd1;
            end
          end
        end
        SET_HR: begin
          if (mode_evt) begin
            state <= SET_MIN;
          end else if (inc_evt) begin
            hours <= (hours == 5'd23) ? '0 : hours + 5'd1;
          end
        end
        SET_MIN: begin
          // Leaving the editor restarts the second so the new time starts cleanly.
          if (mode_evt) begin
            state   <= RUN;
            seconds <= '0;
          end else if (inc_evt) begin
            minutes <= (minutes == 6'd59) ? '0 : minutes + 6'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: a time-of-day model tracked as seconds since midnight,
// checked every cycle, plus hand-computed expectations at key points.
module tb_clock_set_ctrl;

  localparam int CLK_HZ = 10;
  localparam int DB     = 4;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       pb_mode;
  logic       pb_inc;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [1:0] mode_state;
  logic       blink;
  logic       led;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk_in = ~clk_in;

  clock_set_ctrl #(
    .CLK_HZ          (CLK_HZ),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .pb_mode    (pb_mode),
    .pb_inc     (pb_inc),
    .hours      (hours),
    .minutes    (minutes),
    .seconds    (seconds),
    .mode_state (mode_state),
    .blink      (blink),
    .led        (led)
  );

  // Model state: mode number, seconds since midnight, prescaler phase, button debounce.
  int       edge_n   = 0;
  bit       model_ok = 1'b0;
  int       m_state  = 0;
  int       m_tsec   = 0;
  int       m_presc  = 0;
  bit [1:0] m_r1     = '0;
  bit [1:0] m_r2     = '0;
  bit [1:0] m_lvl    = '0;
  int       m_cnt    [2];
  int       m_evt_at [2];

  // A debounced rise at edge n acts on the clock registers at edge n+2.
  always @(posedge clk_in) begin : model
    bit [1:0] seen;
    bit       mode_ev;
    bit       inc_ev;
    bit       tick;
    bit       clear;
    int       mm;
    edge_n++;
    if (rst) begin
      m_state = 0;
      m_tsec  = 0;
      m_presc = 0;
      m_r1    = '0;
      m_r2    = '0;
      m_lvl   = '0;
      for (int b = 0; b < 2; b++) begin
        m_cnt[b]    = 0;
        m_evt_at[b] = -1;
      end
    end else begin
      mode_ev = (m_evt_at[0] == edge_n);
      inc_ev  = (m_evt_at[1] == edge_n);
      seen    = m_r2;
      m_r2    = m_r1;
      m_r1    = {pb_inc, pb_mode};
      for (int b = 0; b < 2; b++) begin
        if (seen[b] != m_lvl[b]) begin
          m_cnt[b]++;
          if (m_cnt[b] == DB) begin
            m_lvl[b] = seen[b];
            m_cnt[b] = 0;
            if (m_lvl[b]) m_evt_at[b] = edge_n + 2;
          end
        end else begin
          m_cnt[b] = 0;
        end
      end
      tick  = (m_presc == CLK_HZ - 1);
      clear = 1'b0;
      case (m_state)
        0: begin
          if (tick) m_tsec = (m_tsec + 1) % 86400;
          if (mode_ev) m_state = 1;
        end
        1: begin
          if (mode_ev) m_state = 2;
          else if (inc_ev) m_tsec = ((m_tsec / 3600 + 1) % 24) * 3600 + m_tsec % 3600;
        end
        default: begin
          if (mode_ev) begin
            m_state = 0;
            m_tsec  = m_tsec - m_tsec % 60;
            clear   = 1'b1;
          end else if (inc_ev) begin
            mm     = (m_tsec / 60) % 60;
            m_tsec = m_tsec - mm * 60 + ((mm + 1) % 60) * 60;
          end
        end
      endcase
      m_presc = clear ? 0 : (m_presc + 1) % CLK_HZ;
    end
    model_ok = 1'b1;
  end

  always @(negedge clk_in) begin : compare
    int exp_h;
    int exp_m;
    int exp_s;
    bit exp_blink;
    if (model_ok) begin
      exp_h     = m_tsec / 3600;
      exp_m     = (m_tsec / 60) % 60;
      exp_s     = m_tsec % 60;
      exp_blink = (m_state != 0) && (m_presc < CLK_HZ / 2);
      n_compared++;
      if (hours !== 5'(exp_h) || minutes !== 6'(exp_m) || seconds !== 6'(exp_s) ||
          mode_state !== 2'(m_state) || blink !== exp_blink || led !== (m_state != 0)) begin
        n_mismatched++;
        $display("[TB] FAIL model edge %0d: got %0d:%0d:%0d mode=%0d blink=%0b led=%0b, expected %0d:%0d:%0d mode=%0d blink=%0b led=%0b",
                 edge_n, hours, minutes, seconds, mode_state, blink, led,
                 exp_h, exp_m, exp_s, m_state, exp_blink, (m_state != 0));
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic m, input logic i, input int cycles);
    pb_mode = m;
    pb_inc  = i;
    repeat (cycles) @(negedge clk_in);
  endtask

  // Event lands on the 8th edge after the rise; the release gap lets both levels fall back.
  task automatic pressButton(input logic m, input logic i);
    applyStimulus(m, i, 8);
    applyStimulus(1'b0, 1'b0, 8);
  endtask

  task automatic checkZeros(input string name);
    checkOutput({name, "_hours"}, int'(hours), 0);
    checkOutput({name, "_minutes"}, int'(minutes), 0);
    checkOutput({name, "_seconds"}, int'(seconds), 0);
    checkOutput({name, "_mode"}, int'(mode_state), 0);
    checkOutput({name, "_blink"}, int'(blink), 0);
    checkOutput({name, "_led"}, int'(led), 0);
  endtask

  initial begin
    rst     = 1'b1;
    pb_mode = 1'b0;
    pb_inc  = 1'b0;
    repeat (3) @(negedge clk_in);
    checkZeros("reset");
    rst = 1'b0;

    applyStimulus(1'b0, 1'b0, 9);
    checkOutput("sec_before_tick", int'(seconds), 0);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("sec_first_tick", int'(seconds), 1);
    applyStimulus(1'b0, 1'b0, 590);
    checkOutput("idle600_hours", int'(hours), 0);
    checkOutput("idle600_minutes", int'(minutes), 1);
    checkOutput("idle600_seconds", int'(seconds), 0);
    checkOutput("idle600_mode", int'(mode_state), 0);

    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 12);
    checkOutput("glitch_mode", int'(mode_state), 0);

    applyStimulus(1'b1, 1'b0, 7);
    checkOutput("mode_at_7", int'(mode_state), 0);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("mode_at_8", int'(mode_state), 1);
    checkOutput("led_set_hr", int'(led), 1);
    checkOutput("blink_set_hr", int'(blink), 1);
    checkOutput("frozen_minutes", int'(minutes), 1);
    checkOutput("frozen_seconds", int'(seconds), 2);
    applyStimulus(1'b0, 1'b0, 8);

    pressButton(1'b1, 1'b1);
    checkOutput("both_mode", int'(mode_state), 2);
    checkOutput("both_hours", int'(hours), 0);
    checkOutput("both_minutes", int'(minutes), 1);

    for (int k = 0; k < 58; k++) pressButton(1'b0, 1'b1);
    checkOutput("min_to_59", int'(minutes), 59);
    pressButton(1'b0, 1'b1);
    checkOutput("min_wrap", int'(minutes), 0);
    checkOutput("min_wrap_hours", int'(hours), 0);
    checkOutput("min_wrap_seconds", int'(seconds), 2);
    for (int k = 0; k < 59; k++) pressButton(1'b0, 1'b1);
    checkOutput("min_back_59", int'(minutes), 59);

    pressButton(1'b1, 1'b0);
    checkOutput("back_run_mode", int'(mode_state), 0);
    checkOutput("back_run_seconds", int'(seconds), 0);
    checkOutput("back_run_led", int'(led), 0);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("presc_restart_9", int'(seconds), 0);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("presc_restart_10", int'(seconds), 1);

    pressButton(1'b1, 1'b0);
    checkOutput("enter_set_hr", int'(mode_state), 1);
    for (int k = 0; k < 23; k++) pressButton(1'b0, 1'b1);
    checkOutput("hr_to_23", int'(hours), 23);
    pressButton(1'b0, 1'b1);
    checkOutput("hr_wrap", int'(hours), 0);
    checkOutput("hr_wrap_minutes", int'(minutes), 59);
    for (int k = 0; k < 23; k++) pressButton(1'b0, 1'b1);
    checkOutput("hr_back_23", int'(hours), 23);

    pressButton(1'b1, 1'b0);
    pressButton(1'b1, 1'b0);
    checkOutput("preload_hours", int'(hours), 23);
    checkOutput("preload_minutes", int'(minutes), 59);
    checkOutput("preload_seconds", int'(seconds), 0);
    applyStimulus(1'b0, 1'b0, 582);
    checkOutput("sec_59", int'(seconds), 59);
    applyStimulus(1'b0, 1'b0, 9);
    checkOutput("last_hours", int'(hours), 23);
    checkOutput("last_minutes", int'(minutes), 59);
    checkOutput("last_seconds", int'(seconds), 59);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("midnight_hours", int'(hours), 0);
    checkOutput("midnight_minutes", int'(minutes), 0);
    checkOutput("midnight_seconds", int'(seconds), 0);

    pressButton(1'b1, 1'b0);
    pressButton(1'b1, 1'b0);
    checkOutput("caseA_set_min", int'(mode_state), 2);
    applyStimulus(1'b1, 1'b0, 3);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1);
    checkZeros("caseA_rst");
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 20);
    checkOutput("caseA_no_event", int'(mode_state), 0);

    pressButton(1'b1, 1'b0);
    pressButton(1'b1, 1'b0);
    checkOutput("caseB_set_min", int'(mode_state), 2);
    applyStimulus(1'b1, 1'b0, 3);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1);
    checkZeros("caseB_rst");
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 7);
    checkOutput("caseB_mode_7", int'(mode_state), 0);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("caseB_mode_8", int'(mode_state), 1);
    applyStimulus(1'b0, 1'b0, 20);
    checkOutput("caseB_single", int'(mode_state), 1);

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 2);
    rst = 1'b0;
    pressButton(1'b0, 1'b1);
    checkOutput("run_inc_minutes", int'(minutes), 0);
    checkOutput("run_inc_hours", int'(hours), 0);
    checkOutput("run_inc_seconds", int'(seconds), 1);
    checkOutput("run_inc_mode", int'(mode_state), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100000000, giving clk_in cycles per 1 s tick.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, giving the consecutive stable samples required to accept a button level.
REQ-003 The block SHALL have port clk_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port pb_mode, input, 1 bit: raw, asynchronous mode pushbutton, active-high.
REQ-006 The block SHALL have port pb_inc, input, 1 bit: raw, asynchronous increment pushbutton, active-high.
REQ-007 The block SHALL have port hours, output, 5 bits: current hour, 0-23.
REQ-008 The block SHALL have port minutes, output, 6 bits: current minute, 0-59.
REQ-009 The block SHALL have port seconds, output, 6 bits: current second, 0-59.
REQ-010 The block SHALL have port mode_state, output, 2 bits: 0=RUN, 1=SET_HR, 2=SET_MIN; 3 is never driven.
REQ-011 The block SHALL have port blink, output, 1 bit: display-blank strobe for the field being edited.
REQ-012 The block SHALL have port led, output, 1 bit: high while in any set state.

Function
REQ-013 Each pb input SHALL pass through a 2-FF synchronizer before any other use.
REQ-014 Each debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch gap resets that button's count.
REQ-015 A press event SHALL be a one-cycle internal pulse on the 0->1 transition of a debounced level; 1->0 produces no event.
REQ-016 The prescaler SHALL count 0..CLK_HZ-1 and wrap; tick = 1 on the cycle it equals CLK_HZ-1. It runs in all states.
REQ-017 FSM transitions on mode event: RUN->SET_HR->SET_MIN->RUN; no other transitions exist.
REQ-018 On SET_MIN->RUN, seconds and the prescaler SHALL be cleared to 0 on the same edge.
REQ-019 In RUN, tick SHALL increment seconds; 59->0 carries into minutes; minutes 59->0 carries into hours; hours 23->0; 23:59:59 + tick -> 00:00:00.
REQ-020 In SET_HR and SET_MIN, ticks SHALL NOT change hours, minutes or seconds (time frozen).
REQ-021 In SET_HR, an inc event SHALL set hours = (hours+1) mod 24; in SET_MIN, minutes = (minutes+1) mod 60 with no carry into hours; in RUN, inc events are ignored.
REQ-022 If mode and inc events occur in the same cycle, the mode transition SHALL be taken and the inc SHALL be dropped.
REQ-023 Register updates SHALL be visible on the edge following the event pulse: raw-edge-to-output latency is 2 + DEBOUNCE_CYCLES + 2 cycles.
REQ-024 blink SHALL be 1 when in a set state and prescaler < CLK_HZ/2 (integer division), and 0 otherwise; led = (mode_state != 0). Both are registered.

Reset
REQ-025 While rst = 1 at a clk_in edge: hours = minutes = seconds = 0, mode_state = 0, prescaler = 0, debounce counters = 0, debounced levels = 0, blink = 0, led = 0.
REQ-026 Reset SHALL take priority over all events, including during an ongoing debounce or in a set state; a button held through reset release SHALL yield exactly one press event after debounce.

Verification (CLK_HZ=10, DEBOUNCE_CYCLES=4)
REQ-027 Reset, then 600 cycles idle -> seconds advances every 10 cycles; at cycle 600, time = 00:01:00, mode_state = 0.
REQ-028 Preload 23:59:59 via set sequence/ticks, one tick -> 00:00:00 on the same edge as the tick cycle.
REQ-029 pb_mode glitch of 3 cycles -> no event, mode_state stays 0; 8-cycle pulse -> mode_state = 1 exactly 8 cycles after the raw rise; led = 1.
REQ-030 In SET_HR at hours = 23, one inc press -> hours = 0; in SET_MIN at minutes = 59, one inc press -> minutes = 0, hours unchanged; seconds constant throughout.
REQ-031 pb_mode and pb_inc rise together in SET_HR -> mode_state = 2, hours unchanged; a further mode press -> mode_state = 0, seconds = 0, prescaler restarted.
REQ-032 rst asserted for 1 cycle in SET_MIN mid-debounce -> all outputs 0 next edge, no event from the interrupted press unless the button is still held for a full debounce.
